// File: rtl/counter_scheduler_pkg.sv
// Shared types and constants for the two-requester counter scheduler.
package counter_scheduler_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // IDLE | waiting for a request, counter cleared, no owner
  // RUN  | owner granted, counter advancing while en is high
  // DONE | terminal count reached, one-cycle completion pulse
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Round-robin pick between two requesters. ptr names the last-served
  // requester, so on a tie the other one wins. A lone request always wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
    logic winner;
    if (req == 2'b11) winner = ~ptr;
    else              winner = req[1];
    return winner;
  endfunction

endpackage

// File: rtl/counter_scheduler_up_counter.sv
// Shared up-counter datapath: synchronous clear has priority over enable.
module up_counter
  import counter_scheduler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Counter register: clear wins, otherwise step by one when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      q <= '0;
    else if (clear) q <= '0;
    else if (en)    q <= q + WIDTH'(1);
  end

endmodule

// File: rtl/counter_scheduler.sv
// Two-requester round-robin scheduler owning one shared up-counter.
// The winner's terminal count is latched at grant, so later changes to
// len0/len1 do not disturb a run in progress.
module counter_scheduler
  import counter_scheduler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  input  logic             en,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [1:0]       gnt_r, gnt_nxt;
  logic [WIDTH-1:0] len_r, len_nxt;
  logic             ptr, ptr_nxt;
  logic             owner;
  logic             winner;
  logic             cnt_clear;
  logic             cnt_en;

  // gnt is one-hot, so its upper bit is the owner's index.
  assign owner = gnt_r[1];

  up_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .q     (q)
  );

  // Control registers; pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt_r <= 2'b00;
      len_r <= '0;
      ptr   <= 1'b1;
    end else begin
      state <= state_nxt;
      gnt_r <= gnt_nxt;
      len_r <= len_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state, arbitration and counter control.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_r;
    len_nxt   = len_r;
    ptr_nxt   = ptr;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    winner    = rr_pick(req, ptr);

    case (state)
      IDLE: begin
        if (|req) begin
          gnt_nxt   = winner ? 2'b10 : 2'b01;
          len_nxt   = winner ? len1 : len0;
          cnt_clear = 1'b1;
          state_nxt = RUN;
        end
      end

      RUN: begin
        // Owner withdrawing its request aborts silently; it still counts
        // as served for round-robin purposes.
        if (!req[owner]) begin
          gnt_nxt   = 2'b00;
          cnt_clear = 1'b1;
          ptr_nxt   = owner;
          state_nxt = IDLE;
        end else if (en) begin
          if (q == len_r) state_nxt = DONE;
          else            cnt_en    = 1'b1;
        end
      end

      DONE: begin
        // Always return through IDLE so there is no back-to-back grant.
        gnt_nxt   = 2'b00;
        cnt_clear = 1'b1;
        ptr_nxt   = owner;
        state_nxt = IDLE;
      end

      default: begin
        gnt_nxt   = 2'b00;
        cnt_clear = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  assign gnt  = gnt_r;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler: each task drives one scenario and
// checks outputs on the falling edge against hand-computed values.
module tb_counter_scheduler;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   req = 2'b00;
  logic [W-1:0] len0 = '0;
  logic [W-1:0] len1 = '0;
  logic         en = 1'b1;
  logic [1:0]   gnt;
  logic [W-1:0] q;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  counter_scheduler #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len0  (len0),
    .len1  (len1),
    .en    (en),
    .gnt   (gnt),
    .q     (q),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    checks++; if (q !== 4'd0)     begin errors++; $display("FAIL reset_q: got %0d expected 0", q); end
    checks++; if (gnt !== 2'b00)  begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 2'b00)  begin errors++; $display("FAIL idle_gnt: got %b expected 00", gnt); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_run();
    logic [W-1:0] exp_q;
    req = 2'b01; len0 = 4'd3; en = 1'b1;
    for (int n = 0; n <= 4; n++) begin
      @(negedge clk);
      exp_q = (n < 4) ? W'(n) : 4'd3;
      checks++; if (gnt !== 2'b01)     begin errors++; $display("FAIL single_gnt n=%0d: got %b expected 01", n, gnt); end
      checks++; if (q !== exp_q)       begin errors++; $display("FAIL single_q n=%0d: got %0d expected %0d", n, q, exp_q); end
      checks++; if (done !== (n == 4)) begin errors++; $display("FAIL single_done n=%0d: got %b expected %b", n, done, (n == 4)); end
      checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL single_busy n=%0d: got %b expected 1", n, busy); end
    end
    req = 2'b00;
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL single_end_gnt: got %b expected 00", gnt); end
    checks++; if (q !== 4'd0)    begin errors++; $display("FAIL single_end_q: got %0d expected 0", q); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_end_done: got %b expected 0", done); end
  endtask

  task automatic test_tie();
    logic [W-1:0] exp_q;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = 2'b11; len0 = 4'd2; len1 = 4'd4; en = 1'b1;
    for (int n = 0; n <= 3; n++) begin
      @(negedge clk);
      exp_q = (n < 3) ? W'(n) : 4'd2;
      checks++; if (gnt !== 2'b01)     begin errors++; $display("FAIL tie_a_gnt n=%0d: got %b expected 01", n, gnt); end
      checks++; if (q !== exp_q)       begin errors++; $display("FAIL tie_a_q n=%0d: got %0d expected %0d", n, q, exp_q); end
      checks++; if (done !== (n == 3)) begin errors++; $display("FAIL tie_a_done n=%0d: got %b expected %b", n, done, (n == 3)); end
    end
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL tie_gap_gnt: got %b expected 00", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tie_gap_busy: got %b expected 0", busy); end
    for (int n = 0; n <= 5; n++) begin
      @(negedge clk);
      exp_q = (n < 5) ? W'(n) : 4'd4;
      checks++; if (gnt !== 2'b10)     begin errors++; $display("FAIL tie_b_gnt n=%0d: got %b expected 10", n, gnt); end
      checks++; if (q !== exp_q)       begin errors++; $display("FAIL tie_b_q n=%0d: got %0d expected %0d", n, q, exp_q); end
      checks++; if (done !== (n == 5)) begin errors++; $display("FAIL tie_b_done n=%0d: got %b expected %b", n, done, (n == 5)); end
    end
    req = 2'b00;
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL tie_end_gnt: got %b expected 00", gnt); end
  endtask

  task automatic test_pause();
    int q_tab [11];
    q_tab = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 6};
    req = 2'b10; len1 = 4'd6; en = 1'b1;
    for (int n = 0; n <= 10; n++) begin
      @(negedge clk);
      checks++; if (gnt !== 2'b10)          begin errors++; $display("FAIL pause_gnt n=%0d: got %b expected 10", n, gnt); end
      checks++; if (q !== W'(q_tab[n]))     begin errors++; $display("FAIL pause_q n=%0d: got %0d expected %0d", n, q, q_tab[n]); end
      checks++; if (done !== (n == 10))     begin errors++; $display("FAIL pause_done n=%0d: got %b expected %b", n, done, (n == 10)); end
      if (n == 2) en = 1'b0;
      if (n == 5) en = 1'b1;
    end
    req = 2'b00;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pause_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_abort_zero();
    req = 2'b01; len0 = 4'd9; len1 = 4'd0; en = 1'b1;
    for (int n = 0; n <= 4; n++) begin
      @(negedge clk);
      checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL abort_gnt n=%0d: got %b expected 01", n, gnt); end
      checks++; if (q !== W'(n))   begin errors++; $display("FAIL abort_q n=%0d: got %0d expected %0d", n, q, n); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done n=%0d: got %b expected 0", n, done); end
      if (n == 2) req = 2'b11;
      if (n == 4) req = 2'b10;
    end
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL abort_idle_gnt: got %b expected 00", gnt); end
    checks++; if (q !== 4'd0)    begin errors++; $display("FAIL abort_idle_q: got %0d expected 0", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_idle_done: got %b expected 0", done); end
    @(negedge clk);
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL zero_gnt: got %b expected 10", gnt); end
    checks++; if (q !== 4'd0)    begin errors++; $display("FAIL zero_q: got %0d expected 0", q); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_run_done: got %b expected 0", done); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
    checks++; if (q !== 4'd0)    begin errors++; $display("FAIL zero_done_q: got %0d expected 0", q); end
    req = 2'b00;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_len_change();
    logic [W-1:0] exp_q;
    req = 2'b01; len0 = 4'd2; en = 1'b1;
    for (int n = 0; n <= 3; n++) begin
      @(negedge clk);
      exp_q = (n < 3) ? W'(n) : 4'd2;
      checks++; if (q !== exp_q)       begin errors++; $display("FAIL lenchg_q n=%0d: got %0d expected %0d", n, q, exp_q); end
      checks++; if (done !== (n == 3)) begin errors++; $display("FAIL lenchg_done n=%0d: got %b expected %b", n, done, (n == 3)); end
      if (n == 0) len0 = 4'd7;
    end
    req = 2'b00;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lenchg_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] g_tab [8];
    int         q_tab [8];
    logic       d_tab [8];
    logic       b_tab [8];
    g_tab = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    q_tab = '{0, 1, 1, 0, 0, 1, 1, 0};
    d_tab = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    b_tab = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    req = 2'b01; len0 = 4'd1; en = 1'b1;
    for (int n = 0; n <= 7; n++) begin
      @(negedge clk);
      checks++; if (gnt !== g_tab[n])      begin errors++; $display("FAIL b2b_gnt n=%0d: got %b expected %b", n, gnt, g_tab[n]); end
      checks++; if (q !== W'(q_tab[n]))    begin errors++; $display("FAIL b2b_q n=%0d: got %0d expected %0d", n, q, q_tab[n]); end
      checks++; if (done !== d_tab[n])     begin errors++; $display("FAIL b2b_done n=%0d: got %b expected %b", n, done, d_tab[n]); end
      checks++; if (busy !== b_tab[n])     begin errors++; $display("FAIL b2b_busy n=%0d: got %b expected %b", n, busy, b_tab[n]); end
      if (n == 6) req = 2'b00;
    end
  endtask

  task automatic test_reset_mid_count();
    logic [W-1:0] exp_q;
    req = 2'b01; len0 = 4'd5; en = 1'b1;
    for (int n = 0; n <= 3; n++) begin
      @(negedge clk);
      checks++; if (q !== W'(n)) begin errors++; $display("FAIL rstmid_q n=%0d: got %0d expected %0d", n, q, n); end
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (q !== 4'd0)    begin errors++; $display("FAIL rstmid_async_q: got %0d expected 0", q); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rstmid_async_gnt: got %b expected 00", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_async_busy: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rstmid_held_gnt: got %b expected 00", gnt); end
    reset = 1'b0;
    for (int n = 0; n <= 6; n++) begin
      @(negedge clk);
      exp_q = (n < 6) ? W'(n) : 4'd5;
      checks++; if (gnt !== 2'b01)     begin errors++; $display("FAIL rstmid_re_gnt n=%0d: got %b expected 01", n, gnt); end
      checks++; if (q !== exp_q)       begin errors++; $display("FAIL rstmid_re_q n=%0d: got %0d expected %0d", n, q, exp_q); end
      checks++; if (done !== (n == 6)) begin errors++; $display("FAIL rstmid_re_done n=%0d: got %b expected %b", n, done, (n == 6)); end
    end
    req = 2'b00;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_end_busy: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_tie();
    test_pause();
    test_abort_zero();
    test_len_change();
    test_back_to_back();
    test_reset_mid_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
